// File: rtl/ins_fetch_if.sv
// Instruction-memory read port shared by the fetch stage and the memory.
//
// Handshake: the master raises mem_req with MEM_ADDR. It holds both steady
// until it samples mem_ack=1 on a rising clock edge. MEM_DATA is meaningful
// only in a cycle where mem_ack=1. The slave may raise mem_ack in the first
// cycle that mem_req is high, or any number of cycles later. The master
// ignores mem_ack in any cycle where it has no request outstanding.
//
// Signals:
//   mem_req   master -> slave  read request
//   MEM_ADDR  master -> slave  word address (PC_W bits)
//   mem_ack   slave  -> master data returned this cycle
//   MEM_DATA  slave  -> master instruction word (INS_W bits)
interface ins_fetch_if #(
  parameter int PC_W  = 4,
  parameter int INS_W = 9
);
  logic             mem_req;
  logic [PC_W-1:0]  MEM_ADDR;
  logic             mem_ack;
  logic [INS_W-1:0] MEM_DATA;

  modport master (output mem_req, output MEM_ADDR, input mem_ack, input MEM_DATA);
  modport slave  (input mem_req, input MEM_ADDR, output mem_ack, output MEM_DATA);
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch stage feeding the instruction decoder.
// The stage owns the program counter. It reads one word at a time from
// instruction memory and presents that word, registered, on INS. It supports
// downstream stall, a jump redirect and a halt word that stops fetching.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   run         fetch enable; 0 parks the stage in IDLE between instructions
//   stall       downstream not ready; INS is held while ins_valid=1
//   jump_en     redirect, taken only when the current instruction is consumed
//   JUMP_ADDR   redirect target
//   mem         instruction-memory read port (master side)
//   INS         registered instruction word to the decoder
//   ins_valid   INS holds a live instruction
//   PC          address of the next instruction to fetch
//   halted      HALT_WORD was fetched; only reset leaves this condition
//   fsm_state   current state (0 IDLE, 1 FETCH, 2 ISSUE, 3 HALT)
// Every output comes from a register, so no path runs from an input to an output.
module ins_fetch #(
  parameter int               PC_W      = 4,
  parameter int               INS_W     = 9,
  parameter logic [INS_W-1:0] HALT_WORD = 9'h1FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [PC_W-1:0]   JUMP_ADDR,
  ins_fetch_if.master       mem,
  output logic [INS_W-1:0]  INS,
  output logic              ins_valid,
  output logic [PC_W-1:0]   PC,
  output logic              halted,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      PC           <= '0;
      mem.MEM_ADDR <= '0;
      mem.mem_req  <= 1'b0;
      INS          <= '0;
      ins_valid    <= 1'b0;
      halted       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state        <= FETCH;
            mem.mem_req  <= 1'b1;
            mem.MEM_ADDR <= PC;
          end
        end

        // The request is not withdrawn when run drops. It stays open until the memory acks.
        FETCH: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (mem.MEM_DATA == HALT_WORD) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              INS       <= mem.MEM_DATA;
              ins_valid <= 1'b1;
              PC        <= PC + 1'b1;
              state     <= ISSUE;
            end
          end
        end

        // PC was already incremented on the ack. A jump taken at consume
        // replaces that incremented value. The next request goes straight
        // to the new PC, which keeps MEM_ADDR equal to PC while mem_req=1.
        ISSUE: begin
          if (!stall) begin
            ins_valid <= 1'b0;
            if (jump_en) begin
              PC <= JUMP_ADDR;
            end
            if (run) begin
              state        <= FETCH;
              mem.mem_req  <= 1'b1;
              mem.MEM_ADDR <= jump_en ? JUMP_ADDR : PC;
            end else begin
              state <= IDLE;
            end
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
